// File: rtl/simmem_addr_arbiter.sv
// Round-robin arbiter for one simmem address channel: one-entry registered output
// stage, source tagging and per-requester credit counters returned by completions.
module simmem_addr_arbiter #(
    parameter int NumReq         = 4,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 4,
    localparam int SrcW          = $clog2(NumReq),
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_valid_i,
    output logic [NumReq-1:0]         req_ready_o,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DataWidth-1:0]      out_data_o,
    output logic [SrcW-1:0]           out_src_o,
    input  logic                      done_valid_i,
    input  logic [SrcW-1:0]           done_src_i,
    output logic [NumReq*CntW-1:0]    outstanding_o,
    output logic                      err_o
);

    logic                 out_valid_q, out_valid_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic [SrcW-1:0]      out_src_q, out_src_d;
    logic [SrcW-1:0]      ptr_q, ptr_d;
    logic [CntW-1:0]      cnt_q [NumReq];
    logic [CntW-1:0]      cnt_d [NumReq];
    logic                 err_q, err_d;

    logic [NumReq-1:0]    eligible;
    logic                 slot_free;
    logic                 found;
    logic                 grant;
    logic [SrcW-1:0]      grant_idx;

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            eligible[k] = req_valid_i[k] && (cnt_q[k] < CntW'(MaxOutstanding));
        end
        slot_free = !out_valid_q || out_ready_i;

        // Search starts at ptr and wraps; the first hit wins.
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % NumReq;
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = SrcW'(idx);
            end
        end
        grant = slot_free && found && !rst_i;

        req_ready_o = '0;
        if (grant) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        err_d       = err_q;

        if (slot_free) begin
            out_valid_d = grant;
        end
        if (grant) begin
            out_data_d = req_data_i[int'(grant_idx)*DataWidth +: DataWidth];
            out_src_d  = grant_idx;
            if (int'(grant_idx) == NumReq - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = SrcW'(grant_idx + 1'b1);
            end
        end

        if (done_valid_i && (int'(done_src_i) >= NumReq)) begin
            err_d = 1'b1;
        end

        for (int k = 0; k < NumReq; k++) begin
            logic inc, dec;
            inc      = grant && (grant_idx == SrcW'(k));
            dec      = done_valid_i && (done_src_i == SrcW'(k));
            cnt_d[k] = cnt_q[k];
            if (inc && !dec) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[k] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NumReq; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            for (int k = 0; k < NumReq; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            outstanding_o[k*CntW +: CntW] = cnt_q[k];
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_simmem_addr_arbiter.sv
// Directed bench for simmem_addr_arbiter: a reference model predicts grants and
// counters each cycle, and expected {src,data} entries are queued until drained.
module tb_simmem_addr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int MO = 4;
    localparam int SW = 2;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            done_valid;
    logic [SW-1:0]   done_src;
    logic [N*CW-1:0] outstanding;
    logic            err;

    always #5 clk = ~clk;

    simmem_addr_arbiter #(.NumReq(N), .DataWidth(DW), .MaxOutstanding(MO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data_i   (req_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_src_o    (out_src),
        .done_valid_i (done_valid),
        .done_src_i   (done_src),
        .outstanding_o(outstanding),
        .err_o        (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int stepno  = 0;

    logic [DW+SW-1:0] sb[$];
    int               m_ptr;
    int               m_cnt[N];
    logic             m_valid;
    logic             m_err;
    logic             use_fixed = 1'b0;
    logic [DW-1:0]    fixed_val = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check against the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic rdy, input logic dv,
                        input logic [SW-1:0] ds, input logic r);
        logic [N-1:0]    exp_ready;
        logic [N*CW-1:0] exp_out;
        logic [DW+SW-1:0] e;
        logic            found;
        int              g;
        stepno++;
        rst        = r;
        req_valid  = v;
        out_ready  = rdy;
        done_valid = dv;
        done_src   = ds;
        for (int k = 0; k < N; k++) begin
            req_data[k*DW +: DW] = use_fixed ? fixed_val
                                 : {32'hC0DE_0000 | 32'(k), 32'(stepno)};
        end
        #1;
        found     = 1'b0;
        g         = 0;
        exp_ready = '0;
        if (!r && (!m_valid || rdy)) begin
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = (m_ptr + i) % N;
                if (!found && v[idx] && m_cnt[idx] < MO) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        if (found) exp_ready[g] = 1'b1;
        for (int k = 0; k < N; k++) exp_out[k*CW +: CW] = CW'(m_cnt[k]);
        chk("req_ready",   DW'(req_ready),   DW'(exp_ready));
        chk("out_valid",   DW'(out_valid),   DW'(m_valid));
        chk("err",         DW'(err),         DW'(m_err));
        chk("outstanding", DW'(outstanding), DW'(exp_out));
        if (!r && m_valid && rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_underflow: observed drain with empty queue, expected none");
            end else begin
                e = sb.pop_front();
                chk("out_src",  DW'(out_src), DW'(e[DW +: SW]));
                chk("out_data", out_data,     e[DW-1:0]);
            end
        end
        if (r) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
            sb.delete();
        end else begin
            if (!m_valid || rdy) begin
                m_valid = found;
                if (found) begin
                    sb.push_back({SW'(g), req_data[g*DW +: DW]});
                    m_ptr = (g + 1) % N;
                end
            end
            if (dv && !(found && int'(ds) == g)) begin
                if (m_cnt[ds] == 0) m_err = 1'b1;
                else m_cnt[ds]--;
            end
            if (found && !(dv && int'(ds) == g)) m_cnt[g]++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; out_ready = 1'b0; req_data = '0;
        done_valid = 1'b0; done_src = '0;
        m_ptr = 0; m_valid = 1'b0; m_err = 1'b0;
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_src", DW'(out_src), '0);

        // Fairness: all valid, no completions, credits run out after 16 grants.
        for (int i = 0; i < 16; i++) step(4'hF, 1'b1, 1'b0, '0, 1'b0);
        chk("fair_full", DW'(outstanding), DW'(12'h924));
        step(4'hF, 1'b1, 1'b0, '0, 1'b0);
        step(4'hF, 1'b1, 1'b0, '0, 1'b0);
        step(4'h0, 1'b0, 1'b0, '0, 1'b1);

        // Backpressure on requester 2.
        use_fixed = 1'b1;
        fixed_val = 64'hA5;
        step(4'b0100, 1'b1, 1'b0, '0, 1'b0);
        fixed_val = 64'hB6;
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 1'b0, 1'b0, '0, 1'b0);
            chk("bp_data", out_data, 64'hA5);
            chk("bp_src", DW'(out_src), DW'(2));
        end
        step(4'b0100, 1'b1, 1'b0, '0, 1'b0);
        chk("bp_next", out_data, 64'hB6);
        step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
        use_fixed = 1'b0;
        step(4'h0, 1'b0, 1'b0, '0, 1'b1);

        // Credit limit on requester 1, then one completion frees one credit.
        for (int i = 0; i < MO; i++) step(4'b0010, 1'b1, 1'b0, '0, 1'b0);
        chk("credit_full", DW'(outstanding[CW +: CW]), DW'(MO));
        step(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        step(4'b0010, 1'b1, 1'b0, '0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, '0, 1'b0);
        step(4'h0, 1'b0, 1'b0, '0, 1'b1);

        // Grant and completion on the same index in the same cycle.
        step(4'b0001, 1'b1, 1'b0, '0, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
        chk("simul_cnt", DW'(outstanding[0 +: CW]), DW'(1));
        chk("simul_err", DW'(err), '0);

        // Underflow completion on requester 3 sets the sticky error.
        step(4'b0000, 1'b1, 1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b0, '0, 1'b0);
        chk("err_sticky", DW'(err), DW'(1));
        step(4'h0, 1'b0, 1'b0, '0, 1'b1);
        chk("err_cleared", DW'(err), '0);

        // Reset mid-stream with counts (1,2,0,1) and a buffered request.
        step(4'b0001, 1'b1, 1'b0, '0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, '0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, '0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, '0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, '0, 1'b0);
        chk("mid_cnts", DW'(outstanding), DW'(12'h211));
        chk("mid_valid", DW'(out_valid), DW'(1));
        step(4'b0000, 1'b0, 1'b0, '0, 1'b1);
        chk("mid_rst_valid", DW'(out_valid), '0);
        chk("mid_rst_cnts", DW'(outstanding), '0);
        step(4'hF, 1'b1, 1'b0, '0, 1'b0);
        chk("mid_restart_src", DW'(out_src), '0);
        step(4'h0, 1'b1, 1'b1, 2'd3, 1'b0);
        step(4'h0, 1'b1, 1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
